// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Synchronizes N_CH asynchronous level inputs, turns their rising/falling
// edges into one pending event per channel, and hands those events out one
// at a time over a valid/ready port using a round-robin scheduler.
module edge_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          in,
  input  logic [N_CH-1:0]          rise_en,
  input  logic [N_CH-1:0]          fall_en,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_CH)-1:0]  evt_ch,
  output logic                     evt_rise,
  output logic [N_CH-1:0]          overflow,
  input  logic [N_CH-1:0]          clr_overflow
);

  localparam int ID_W = $clog2(N_CH);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state;
  logic [N_CH-1:0]   sync_q [SYNC_STAGES];
  logic [N_CH-1:0]   sync_out;
  logic [N_CH-1:0]   prev;
  logic [N_CH-1:0]   edges;
  logic [N_CH-1:0]   cap;
  logic [N_CH-1:0]   cap_ok;
  logic [N_CH-1:0]   ov_set;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   pend_rise;
  logic [N_CH-1:0]   grant_vec;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic              grant_fire;
  logic              handshake;

  // Synchronizer chain per channel followed by the previous-sample register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edges    = sync_out ^ prev;
  // An edge only counts if the enable for its direction is set this cycle.
  assign cap      = (edges & sync_out & rise_en) | (edges & ~sync_out & fall_en);

  // Round-robin search: first pending channel after last_grant, wrapping.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = (int'(last_grant) + i) % N_CH;
      if (!grant_any && pending[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  assign handshake  = (state == OFFER) && evt_ready;
  assign grant_fire = grant_any && ((state == IDLE) || handshake);
  assign grant_vec  = grant_fire ? (N_CH'(1) << grant_idx) : '0;

  // A channel being granted this cycle frees its slot, so a coincident edge
  // is captured instead of being counted as an overflow.
  assign cap_ok = cap & (~pending | grant_vec);
  assign ov_set = cap & pending & ~grant_vec;

  // Pending slots, their direction, and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      pend_rise <= '0;
      overflow  <= '0;
    end else begin
      pending   <= (pending & ~grant_vec) | cap_ok;
      pend_rise <= (cap_ok & sync_out) | (~cap_ok & pend_rise);
      overflow  <= ov_set | (overflow & ~clr_overflow);
    end
  end

  // Scheduler: offers one event, back-to-back grants while handshakes continue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      evt_rise   <= 1'b0;
      last_grant <= ID_W'(N_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            evt_ch     <= grant_idx;
            evt_rise   <= pend_rise[grant_idx];
            last_grant <= grant_idx;
            evt_valid  <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            if (grant_any) begin
              evt_ch     <= grant_idx;
              evt_rise   <= pend_rise[grant_idx];
              last_grant <= grant_idx;
            end else begin
              evt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: per-channel expected-event queues filled
// by the stimulus, drained and compared by an independent output monitor.
module tb_edge_event_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] in_l, rise_en, fall_en, overflow, clr_overflow;
  logic         evt_valid, evt_ready, evt_rise;
  logic [1:0]   evt_ch;

  int total = 0;
  int bad   = 0;

  bit exp_q [N][$];
  int got_log[$];

  edge_event_arbiter #(.N_CH(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .in(in_l), .rise_en(rise_en), .fall_en(fall_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_rise(evt_rise), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < N; c++) if (exp_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      step();
      n++;
    end
    total++;
    if (!all_empty()) begin
      bad++;
      $display("FAIL drain: events still expected after %0d cycles", budget);
      for (int c = 0; c < N; c++) exp_q[c].delete();
    end
  endtask

  task automatic check_order(input string name, input int a, input int b, input int c, input int d, input int len);
    int want[4];
    want = '{a, b, c, d};
    check({name, "_len"}, got_log.size(), len);
    for (int i = 0; i < len && i < got_log.size(); i++) check(name, got_log[i], want[i]);
  endtask

  // Output monitor: stability under backpressure and delivered-event checking.
  initial begin
    logic       hold_seen;
    logic [1:0] hold_ch;
    logic       hold_rise;
    hold_seen = 1'b0;
    hold_ch   = '0;
    hold_rise = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (hold_seen && evt_valid) begin
          check("hold_ch", evt_ch, hold_ch);
          check("hold_rise", evt_rise, hold_rise);
        end
        hold_seen = evt_valid && !evt_ready;
        hold_ch   = evt_ch;
        hold_rise = evt_rise;
        if (evt_valid && evt_ready) begin
          got_log.push_back(int'(evt_ch));
          if (exp_q[evt_ch].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_evt: got ch=%0d rise=%0d want no event", evt_ch, evt_rise);
          end else begin
            check("evt_rise", evt_rise, exp_q[evt_ch].pop_front());
          end
        end
      end else begin
        hold_seen = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic nv;
    in_l = '0; rise_en = '1; fall_en = '1; clr_overflow = '0; evt_ready = 1'b0;
    idle(3);
    check("rst_valid", evt_valid, 0);
    check("rst_ch", evt_ch, 0);
    check("rst_rise", evt_rise, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    idle(2);

    // single edge with latency
    in_l[2] = 1'b1; exp_q[2].push_back(1'b1);
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lat_early", evt_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", evt_valid, 1);
    check("lat_ch", evt_ch, 2);
    check("lat_rise", evt_rise, 1);
    step();
    evt_ready = 1'b1;
    drain(20);
    in_l[2] = 1'b0; exp_q[2].push_back(1'b0);
    drain(20);
    idle(3);

    // round robin from a fresh reset
    reset = 1'b0; step(); reset = 1'b1; idle(2);
    got_log.delete();
    in_l = 4'hF;
    for (int c = 0; c < N; c++) exp_q[c].push_back(1'b1);
    drain(30);
    check_order("rr_all", 0, 1, 2, 3, 4);
    idle(2);
    got_log.delete();
    in_l = 4'h0;
    for (int c = 0; c < N; c++) exp_q[c].push_back(1'b0);
    drain(30);
    check_order("rr_fall", 0, 1, 2, 3, 4);
    idle(2);
    got_log.delete();
    in_l = 4'b1001; exp_q[0].push_back(1'b1); exp_q[3].push_back(1'b1);
    drain(30);
    check_order("rr_03", 0, 3, 0, 0, 2);
    in_l = 4'b0000; exp_q[0].push_back(1'b0); exp_q[3].push_back(1'b0);
    drain(30);
    idle(3);

    // backpressure and overflow
    evt_ready = 1'b0;
    in_l[0] = 1'b1; exp_q[0].push_back(1'b1);
    idle(5);
    in_l[1] = 1'b1; exp_q[1].push_back(1'b1);
    idle(3);
    in_l[1] = 1'b0;
    idle(4);
    check("bp_valid", evt_valid, 1);
    check("bp_ch", evt_ch, 0);
    check("ovf_set", overflow[1], 1);
    check("ovf_other", overflow[0], 0);
    clr_overflow[1] = 1'b1;
    step();
    clr_overflow[1] = 1'b0;
    check("ovf_clr", overflow[1], 0);
    evt_ready = 1'b1;
    drain(20);
    idle(3);

    // enables
    fall_en[0] = 1'b0;
    in_l[0] = 1'b0;
    idle(6);
    check("en_fall_noevt", evt_valid, 0);
    check("en_fall_noovf", overflow[0], 0);
    in_l[0] = 1'b1; exp_q[0].push_back(1'b1);
    drain(20);
    fall_en = '1;
    rise_en[1] = 1'b0;
    in_l[1] = 1'b1;
    idle(6);
    check("en_rise_noevt", evt_valid, 0);
    rise_en = '1;
    idle(2);

    // grant/capture collision on ch1
    in_l[1] = 1'b0; exp_q[1].push_back(1'b0);
    step();
    in_l[1] = 1'b1; exp_q[1].push_back(1'b1);
    drain(20);
    check("coll_ovf", overflow[1], 0);
    idle(3);

    // reset mid-operation
    evt_ready = 1'b0;
    in_l = 4'b1110;
    idle(5);
    in_l[3] = 1'b0;
    idle(4);
    check("pre_rst_valid", evt_valid, 1);
    check("pre_rst_ovf", overflow[3], 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_ch", evt_ch, 0);
    check("mid_rst_rise", evt_rise, 0);
    check("mid_rst_ovf", overflow, 0);
    in_l = 4'b0000;
    step(); step();
    reset = 1'b1;
    idle(2);
    got_log.delete();
    evt_ready = 1'b1;
    in_l = 4'b1001; exp_q[0].push_back(1'b1); exp_q[3].push_back(1'b1);
    drain(30);
    check_order("post_rst", 0, 3, 0, 0, 2);

    // input held high across reset release
    reset = 1'b0;
    in_l = 4'b0100;
    step(); step();
    reset = 1'b1;
    exp_q[2].push_back(1'b1);
    drain(20);
    idle(3);

    // randomized traffic
    for (int r = 0; r < 6; r++) begin
      rise_en = N'($urandom);
      fall_en = N'($urandom);
      idle(4);
      for (int k = 0; k < 200; k++) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < N; c++) begin
          if (exp_q[c].size() == 0 && $urandom_range(0, 3) == 0) begin
            nv = ~in_l[c];
            in_l[c] = nv;
            if (nv ? rise_en[c] : fall_en[c]) exp_q[c].push_back(nv);
          end
        end
        step();
      end
      evt_ready = 1'b1;
      drain(200);
      idle(6);
      check("rand_ovf", overflow, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Collects rising and falling edges from `N_CH` asynchronous level inputs and queues one pending event per channel. A round-robin scheduler shares a single downstream event port among those channels, presenting one event at a time over a valid/ready handshake. It sits between raw external level signals and the event-consuming control logic, replacing per-channel edge-detector FSMs with one shared, arbitrated event stream.

## Interface
- `N_CH`, 4: number of input channels, 2..16.
- `SYNC_STAGES`, 2: synchronizer flops per channel, at least 2.
- `ID_W`, derived localparam: `$clog2(N_CH)`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to `clk` by the system.
- `in`  in  N_CH  raw level inputs, asynchronous to `clk`.
- `rise_en`  in  N_CH  per-channel enable for rising-edge events.
- `fall_en`  in  N_CH  per-channel enable for falling-edge events.
- `evt_valid`  out  1  event offered.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_ch`  out  ID_W  channel index of the offered event.
- `evt_rise`  out  1  1 = rising edge, 0 = falling edge.
- `overflow`  out  N_CH  sticky flag, one per channel: an edge was dropped.
- `clr_overflow`  in  N_CH  per-bit clear for `overflow`.

## Operation
**Reset values.** While `reset` = 0:
- all outputs are 0;
- synchronizer chains, previous-sample registers, `pending`, `pend_rise` and `overflow` are 0;
- `last_grant` = N_CH-1, so channel 0 has first priority;
- FSM is in IDLE.

**Edge detection.**
- Each channel has a `SYNC_STAGES` synchronizer chain, then a `prev` register.
- An edge is `sync_out != prev`; it is rising when `sync_out` = 1.
- An input held high across reset release yields one rising edge.

**Capture.**
- An enabled edge (`rise_en` for rising, `fall_en` for falling, sampled the same cycle) sets `pending[ch]` and loads `pend_rise[ch]`.
- Disabled edges are discarded silently and do not set `overflow`.
- If `pending[ch]` is already set and is not being granted this cycle, the new edge is dropped, `overflow[ch]` is set, and the older event is kept.
- If the channel is being granted in the same cycle, the new edge is captured with no overflow.

**Overflow.**
- Sticky until `clr_overflow[ch]` = 1.
- A simultaneous set and clear: the set wins.

**Scheduler FSM.**
- **IDLE:** if any `pending` bit is set, grant the first set bit searching from `last_grant+1` upward with wrap-around. Load `evt_ch`/`evt_rise`, clear `pending[grant]`, update `last_grant`, go to OFFER. Otherwise stay in IDLE.
- **OFFER:** `evt_valid` = 1. `evt_ch` and `evt_rise` are held stable until the handshake (`evt_valid & evt_ready`).
  - On handshake with any `pending` set: load the next round-robin grant in the same cycle and stay in OFFER.
  - On handshake with none pending: go to IDLE, `evt_valid` = 0.
  - No handshake: stay in OFFER; other channels keep accumulating.
- Changing the enables does not affect events already pending.

## Timing
- All outputs are registered.
- Latency: `in` toggle sampled at edge k → `evt_valid` high after edge k+SYNC_STAGES+1, i.e. 3 cycles for the default.
- Throughput: 1 event per cycle with `evt_ready` held high.
- Fairness: each pending channel is offered within N_CH handshakes.
- `in` pulses shorter than one `clk` period may be missed; this is not flagged.
- Reset asserted mid-offer: `evt_valid` drops immediately, all pending events are lost, `overflow` is cleared.

## Test plan
- **Single edge.** After reset, raise `in[2]` with `rise_en` = 4'hF. Expect `evt_valid` 3 cycles later with `evt_ch` = 2, `evt_rise` = 1. Drop `in[2]`; expect `evt_ch` = 2, `evt_rise` = 0.
- **Round-robin.** Raise `in[3:0]` simultaneously with `evt_ready` = 1. Expect `evt_ch` sequence 0, 1, 2, 3 on consecutive cycles. Then raise ch0 and ch3 together; expect 0 then 3.
- **Backpressure and overflow.** Hold `evt_ready` = 0 and toggle `in[1]` twice. Expect the event held stable with no change to `evt_ch`/`evt_rise`, the first pending edge retained, and `overflow[1]` = 1. Pulse `clr_overflow[1]`; expect `overflow[1]` = 0.
- **Enables.** With `fall_en[0]` = 0, a falling edge on `in[0]` produces no event and no overflow. With `rise_en[0]` = 1, a rising edge produces an event.
- **Grant/capture collision.** Time a new `in[1]` edge to land in the cycle ch1 is granted. Expect the second event delivered and `overflow[1]` = 0.
- **Reset mid-operation.** Assert `reset` low while `evt_valid` = 1 with 2 events pending. Expect all outputs 0 asynchronously. After release, the first grant goes to ch0 on a new edge.
